// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane parking occupancy controller: arbitrates entry lanes against
// free space (exits first), tracks occupancy, and flags full/empty/underflow.
module parking_occupancy_ctrl #(
  parameter int CAPACITY       = 10,
  parameter int N_ENTRY        = 2,
  parameter int N_EXIT         = 2,
  parameter int ALMOST_FULL_TH = 8,
  parameter int CNT_W          = $clog2(CAPACITY+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ENTRY-1:0] entry_req,
  input  logic [N_EXIT-1:0]  exit_evt,
  input  logic               clr_err,
  output logic [N_ENTRY-1:0] entry_grant,
  output logic [N_ENTRY-1:0] entry_deny,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   free_slots,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               err_underflow
);

  localparam int W = CNT_W + 4;
  localparam logic [W-1:0]     CAP_W = W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] TH_C  = CNT_W'(ALMOST_FULL_TH);
  localparam logic             AF_RST = (ALMOST_FULL_TH == 0);

  logic [N_ENTRY-1:0] r_grant;
  logic [N_ENTRY-1:0] r_deny;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_free;
  logic               r_full;
  logic               r_empty;
  logic               r_af;
  logic               r_err;

  logic [W-1:0]       w_cnt;
  logic [W-1:0]       w_n_exit;
  logic [W-1:0]       w_acc;
  logic [W-1:0]       w_room;
  logic [W-1:0]       w_n_grant;
  logic [CNT_W-1:0]   w_next;
  logic [N_ENTRY-1:0] w_grant;
  logic               w_under;

  // Exits are retired before arbitration so they free room this cycle
  always_comb begin
    w_cnt    = W'(r_count);
    w_n_exit = '0;
    for (int i = 0; i < N_EXIT; i++)
      w_n_exit = w_n_exit + W'(exit_evt[i]);
    w_under   = (w_n_exit > w_cnt);
    w_acc     = w_under ? w_cnt : w_n_exit;
    w_room    = CAP_W - w_cnt + w_acc;
    w_grant   = '0;
    w_n_grant = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (entry_req[i] && (w_n_grant < w_room)) begin
        w_grant[i] = 1'b1;
        w_n_grant  = w_n_grant + W'(1);
      end
    end
    w_next = CNT_W'(w_cnt + w_n_grant - w_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_deny  <= '0;
      r_count <= '0;
      r_free  <= CAP_C;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= AF_RST;
      r_err   <= 1'b0;
    end else begin
      r_grant <= w_grant;
      r_deny  <= entry_req & ~w_grant;
      r_count <= w_next;
      r_free  <= CAP_C - w_next;
      r_full  <= (w_next == CAP_C);
      r_empty <= (w_next == '0);
      r_af    <= (w_next >= TH_C);
      if (w_under)
        r_err <= 1'b1;
      else if (clr_err)
        r_err <= 1'b0;
    end
  end

  assign entry_grant   = r_grant;
  assign entry_deny    = r_deny;
  assign count         = r_count;
  assign free_slots    = r_free;
  assign full          = r_full;
  assign empty         = r_empty;
  assign almost_full   = r_af;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Randomized + directed bench for parking_occupancy_ctrl against a
// behavioural occupancy model.
module tb_parking_occupancy_ctrl;

  localparam int CAP = 10;
  localparam int NE  = 2;
  localparam int NX  = 2;
  localparam int TH  = 8;
  localparam int CW  = $clog2(CAP+1);

  logic          clk = 0;
  logic          reset;
  logic [NE-1:0] entry_req;
  logic [NX-1:0] exit_evt;
  logic          clr_err;
  logic [NE-1:0] entry_grant;
  logic [NE-1:0] entry_deny;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          err_underflow;

  int errors = 0;
  int checks = 0;

  int       m_count;
  bit       m_err;
  bit [1:0] m_grant;
  bit [1:0] m_deny;

  parking_occupancy_ctrl #(
    .CAPACITY(CAP), .N_ENTRY(NE), .N_EXIT(NX), .ALMOST_FULL_TH(TH)
  ) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req),
    .exit_evt(exit_evt), .clr_err(clr_err),
    .entry_grant(entry_grant), .entry_deny(entry_deny),
    .count(count), .free_slots(free_slots), .full(full),
    .empty(empty), .almost_full(almost_full),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_err = 0; m_grant = 0; m_deny = 0;
  endtask

  // Spec rules in plain arithmetic: exits free space first, then lanes in order
  task automatic model_step(input bit [1:0] req, input bit [1:0] ex,
                            input bit clr);
    int ne, acc, room, ng;
    ne   = $countones(ex);
    acc  = (ne < m_count) ? ne : m_count;
    room = CAP - m_count + acc;
    ng   = 0;
    m_grant = 0;
    for (int i = 0; i < NE; i++)
      if (req[i] && ng < room) begin
        m_grant[i] = 1;
        ng++;
      end
    m_deny = req & ~m_grant;
    if (ne > m_count) m_err = 1;
    else if (clr) m_err = 0;
    m_count = m_count + ng - acc;
  endtask

  task automatic compare_all();
    chk("grant", int'(entry_grant), int'(m_grant));
    chk("deny", int'(entry_deny), int'(m_deny));
    chk("count", int'(count), m_count);
    chk("free_slots", int'(free_slots), CAP - m_count);
    chk("full", int'(full), int'(m_count == CAP));
    chk("empty", int'(empty), int'(m_count == 0));
    chk("almost_full", int'(almost_full), int'(m_count >= TH));
    chk("err_underflow", int'(err_underflow), int'(m_err));
  endtask

  task automatic step(input bit [1:0] req, input bit [1:0] ex,
                      input bit clr);
    entry_req = req; exit_evt = ex; clr_err = clr;
    @(posedge clk);
    model_step(req, ex, clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    entry_req = 0; exit_evt = 0; clr_err = 0;
    do_reset();
    chk("rst_free_lit", int'(free_slots), 10);

    step(2'b01, 2'b00, 0);
    chk("single_cnt_lit", int'(count), 1);
    chk("single_grant_lit", int'(entry_grant), 1);
    step(2'b11, 2'b00, 0);
    chk("dual_cnt_lit", int'(count), 3);
    repeat (3) step(2'b11, 2'b00, 0);
    chk("nine_lit", int'(count), 9);
    step(2'b11, 2'b00, 0);
    chk("fill_grant_lit", int'(entry_grant), 1);
    chk("fill_deny_lit", int'(entry_deny), 2);
    chk("fill_full_lit", int'(full), 1);
    step(2'b11, 2'b00, 0);
    chk("full_deny_lit", int'(entry_deny), 3);
    step(2'b11, 2'b01, 0);
    chk("swap_cnt_lit", int'(count), 10);
    chk("swap_grant_lit", int'(entry_grant), 1);
    step(2'b00, 2'b11, 0);
    chk("th8_af_lit", int'(almost_full), 1);
    step(2'b00, 2'b01, 0);
    chk("th7_af_lit", int'(almost_full), 0);
    step(2'b01, 2'b00, 0);
    chk("th_rise_af_lit", int'(almost_full), 1);
    repeat (3) step(2'b00, 2'b11, 0);
    step(2'b00, 2'b01, 0);
    chk("one_lit", int'(count), 1);
    step(2'b00, 2'b11, 0);
    chk("uf_cnt_lit", int'(count), 0);
    chk("uf_err_lit", int'(err_underflow), 1);
    step(2'b00, 2'b00, 1);
    chk("clr_lit", int'(err_underflow), 0);
    step(2'b00, 2'b11, 1);
    chk("set_wins_lit", int'(err_underflow), 1);

    step(2'b11, 2'b00, 1);
    step(2'b11, 2'b00, 0);
    step(2'b01, 2'b00, 0);
    chk("five_lit", int'(count), 5);
    do_reset();
    chk("midrst_lit", int'(count), 0);

    for (int k = 0; k < 400; k++) begin
      bit [1:0] r, e;
      r = 2'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step(r, e, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
